// File: rtl/airi5c_wb_arbiter.sv
// Writeback arbiter: merges pipeline and long-latency results onto the RF port.
// Optional AIRI5C_WB_PERF_CNT_EN adds a saturating drain-stall counter.
module airi5c_wb_arbiter #(
   parameter int FIFO_DEPTH     = 2,
   parameter int XPR_LEN        = 32,
   parameter int REG_ADDR_WIDTH = 5
) (
   input  logic                      clk_i,
   input  logic                      rst_ni,
   input  logic                      pipe_wen_i,
   input  logic [REG_ADDR_WIDTH-1:0] pipe_wa_i,
   input  logic [XPR_LEN-1:0]        pipe_wd_i,
   input  logic [XPR_LEN-1:0]        pipe_wd2_i,
   input  logic                      pipe_rd64_i,
   input  logic                      ll_issue_i,
   input  logic [REG_ADDR_WIDTH-1:0] ll_issue_rd_i,
   input  logic                      ll_valid_i,
   output logic                      ll_ready_o,
   input  logic [REG_ADDR_WIDTH-1:0] ll_wa_i,
   input  logic [XPR_LEN-1:0]        ll_wd_i,
   input  logic                      dm_wen_i,
   input  logic [REG_ADDR_WIDTH-1:0] chk_ra1_i,
   input  logic [REG_ADDR_WIDTH-1:0] chk_ra2_i,
   input  logic [REG_ADDR_WIDTH-1:0] chk_wa_i,
   output logic                      hazard_o,
   output logic                      rf_wen_o,
   output logic [REG_ADDR_WIDTH-1:0] rf_wa_o,
   output logic [XPR_LEN-1:0]        rf_wd_o,
   output logic [XPR_LEN-1:0]        rf_wd2_o,
   output logic                      rf_rd64_o,
   output logic [$clog2(FIFO_DEPTH):0] fifo_count_o
`ifdef AIRI5C_WB_PERF_CNT_EN
   ,
   output logic [15:0]               drain_stall_cnt_o
`endif
);

   localparam int AW   = $clog2(FIFO_DEPTH);
   localparam int CW   = AW + 1;
   localparam int NREG = 1 << REG_ADDR_WIDTH;

   typedef struct packed {
      logic [REG_ADDR_WIDTH-1:0] wa;
      logic [XPR_LEN-1:0]        wd;
   } ll_ent_t;

   ll_ent_t           mem [FIFO_DEPTH];
   ll_ent_t           head;
   logic [AW-1:0]     rd_ptr;
   logic [AW-1:0]     wr_ptr;
   logic [CW-1:0]     count;
   logic              empty;
   logic              push;
   logic              pop;
   logic              sel_pipe;
   logic [NREG-1:0]   busy;
   logic [NREG-1:0]   busy_nxt;
   logic              issue_hit;

   // ---------------- FIFO ----------------
   assign empty      = (count == '0);
   assign ll_ready_o = (count != CW'(FIFO_DEPTH));
   assign push       = ll_valid_i & ll_ready_o;
   assign head       = mem[rd_ptr];

   // Debug writes own the port outright; pipeline beats the drain.
   assign sel_pipe = ~dm_wen_i & pipe_wen_i;
   assign pop      = ~dm_wen_i & ~pipe_wen_i & ~empty;

   always_ff @(posedge clk_i) begin
      if (push) begin
         mem[wr_ptr] <= '{wa: ll_wa_i, wd: ll_wd_i};
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
         unique case ({push, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   assign fifo_count_o = count;

   // ---------------- RF write port ----------------
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         rf_wen_o  <= 1'b0;
         rf_wa_o   <= '0;
         rf_wd_o   <= '0;
         rf_wd2_o  <= '0;
         rf_rd64_o <= 1'b0;
      end else if (sel_pipe) begin
         rf_wen_o  <= 1'b1;
         rf_wa_o   <= pipe_wa_i;
         rf_wd_o   <= pipe_wd_i;
         rf_wd2_o  <= pipe_wd2_i;
         rf_rd64_o <= pipe_rd64_i;
      end else if (pop) begin
         rf_wen_o  <= 1'b1;
         rf_wa_o   <= head.wa;
         rf_wd_o   <= head.wd;
         rf_wd2_o  <= '0;
         rf_rd64_o <= 1'b0;
      end else begin
         rf_wen_o  <= 1'b0;
         rf_rd64_o <= 1'b0;
      end
   end

   // ---------------- Scoreboard ----------------
   always_comb begin
      busy_nxt = busy;
      if (pop) busy_nxt[head.wa] = 1'b0;
      // A fresh issue to the draining register must stay pending.
      if (ll_issue_i) busy_nxt[ll_issue_rd_i] = 1'b1;
      busy_nxt[0] = 1'b0;
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) busy <= '0;
      else         busy <= busy_nxt;
   end

   assign issue_hit = ll_issue_i
                    & (ll_issue_rd_i != '0)
                    & ((ll_issue_rd_i == chk_ra1_i)
                     | (ll_issue_rd_i == chk_ra2_i)
                     | (ll_issue_rd_i == chk_wa_i));

   assign hazard_o = busy[chk_ra1_i]
                   | busy[chk_ra2_i]
                   | busy[chk_wa_i]
                   | issue_hit;

`ifdef AIRI5C_WB_PERF_CNT_EN
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         drain_stall_cnt_o <= '0;
      end else if (~empty & (dm_wen_i | pipe_wen_i)
                   & (drain_stall_cnt_o != 16'hFFFF)) begin
         drain_stall_cnt_o <= drain_stall_cnt_o + 16'd1;
      end
   end
`endif

endmodule

// File: tb/tb_airi5c_wb_arbiter.sv
// Bench for airi5c_wb_arbiter: directed scenarios plus randomized
// traffic checked against a queue-based reference model.
module tb_airi5c_wb_arbiter;

   localparam int DEPTH = 2;
   localparam int XL    = 32;
   localparam int RA    = 5;

   logic          clk_i = 1'b0;
   logic          rst_ni;
   logic          pipe_wen_i;
   logic [RA-1:0] pipe_wa_i;
   logic [XL-1:0] pipe_wd_i;
   logic [XL-1:0] pipe_wd2_i;
   logic          pipe_rd64_i;
   logic          ll_issue_i;
   logic [RA-1:0] ll_issue_rd_i;
   logic          ll_valid_i;
   logic          ll_ready_o;
   logic [RA-1:0] ll_wa_i;
   logic [XL-1:0] ll_wd_i;
   logic          dm_wen_i;
   logic [RA-1:0] chk_ra1_i;
   logic [RA-1:0] chk_ra2_i;
   logic [RA-1:0] chk_wa_i;
   logic          hazard_o;
   logic          rf_wen_o;
   logic [RA-1:0] rf_wa_o;
   logic [XL-1:0] rf_wd_o;
   logic [XL-1:0] rf_wd2_o;
   logic          rf_rd64_o;
   logic [$clog2(DEPTH):0] fifo_count_o;
`ifdef AIRI5C_WB_PERF_CNT_EN
   logic [15:0]   drain_stall_cnt_o;
`endif

   airi5c_wb_arbiter #(
      .FIFO_DEPTH(DEPTH), .XPR_LEN(XL), .REG_ADDR_WIDTH(RA)
   ) dut (
      .clk_i(clk_i), .rst_ni(rst_ni),
      .pipe_wen_i(pipe_wen_i), .pipe_wa_i(pipe_wa_i),
      .pipe_wd_i(pipe_wd_i), .pipe_wd2_i(pipe_wd2_i),
      .pipe_rd64_i(pipe_rd64_i),
      .ll_issue_i(ll_issue_i), .ll_issue_rd_i(ll_issue_rd_i),
      .ll_valid_i(ll_valid_i), .ll_ready_o(ll_ready_o),
      .ll_wa_i(ll_wa_i), .ll_wd_i(ll_wd_i),
      .dm_wen_i(dm_wen_i),
      .chk_ra1_i(chk_ra1_i), .chk_ra2_i(chk_ra2_i), .chk_wa_i(chk_wa_i),
      .hazard_o(hazard_o),
      .rf_wen_o(rf_wen_o), .rf_wa_o(rf_wa_o), .rf_wd_o(rf_wd_o),
      .rf_wd2_o(rf_wd2_o), .rf_rd64_o(rf_rd64_o),
      .fifo_count_o(fifo_count_o)
`ifdef AIRI5C_WB_PERF_CNT_EN
      , .drain_stall_cnt_o(drain_stall_cnt_o)
`endif
   );

   always #5 clk_i = ~clk_i;

   int n_tests = 0;
   int n_fail  = 0;

   // ---------------- reference model ----------------
   typedef struct {
      logic [RA-1:0] wa;
      logic [XL-1:0] wd;
   } ent_t;

   ent_t          m_q[$];
   bit            m_busy[32];
   logic          e_wen;
   logic [RA-1:0] e_wa;
   logic [XL-1:0] e_wd;
   logic [XL-1:0] e_wd2;
   logic          e_rd64;
   int            m_stall;

   task automatic model_reset();
      m_q.delete();
      foreach (m_busy[i]) m_busy[i] = 1'b0;
      e_wen = 0; e_wa = 0; e_wd = 0; e_wd2 = 0; e_rd64 = 0;
      m_stall = 0;
   endtask

   function automatic bit m_hazard();
      bit h;
      h = m_busy[chk_ra1_i] | m_busy[chk_ra2_i] | m_busy[chk_wa_i];
      if (ll_issue_i && ll_issue_rd_i != 0 &&
          (ll_issue_rd_i == chk_ra1_i || ll_issue_rd_i == chk_ra2_i ||
           ll_issue_rd_i == chk_wa_i))
         h = 1;
      return h;
   endfunction

   // One clock: predict from current inputs, then advance model and DUT.
   task automatic tick();
      int   sz;
      bit   pop, push;
      ent_t hd, nw;
      sz   = m_q.size();
      pop  = !dm_wen_i && !pipe_wen_i && sz > 0;
      push = ll_valid_i && sz < DEPTH;
      nw.wa = ll_wa_i;
      nw.wd = ll_wd_i;
      if (sz > 0) hd = m_q[0];
      if (sz > 0 && (dm_wen_i || pipe_wen_i) && m_stall < 65535)
         m_stall++;
      @(posedge clk_i);
      #1;
      if (dm_wen_i) e_wen = 0;
      else if (pipe_wen_i) begin
         e_wen = 1; e_wa = pipe_wa_i; e_wd = pipe_wd_i;
         e_wd2 = pipe_wd2_i; e_rd64 = pipe_rd64_i;
      end else if (pop) begin
         e_wen = 1; e_wa = hd.wa; e_wd = hd.wd; e_wd2 = 0; e_rd64 = 0;
      end else e_wen = 0;
      if (pop) begin
         void'(m_q.pop_front());
         m_busy[hd.wa] = 0;
      end
      if (ll_issue_i && ll_issue_rd_i != 0) m_busy[ll_issue_rd_i] = 1;
      if (push) m_q.push_back(nw);
   endtask

   task automatic idle();
      pipe_wen_i = 0; pipe_wa_i = 0; pipe_wd_i = 0; pipe_wd2_i = 0;
      pipe_rd64_i = 0; ll_issue_i = 0; ll_issue_rd_i = 0;
      ll_valid_i = 0; ll_wa_i = 0; ll_wd_i = 0; dm_wen_i = 0;
      chk_ra1_i = 0; chk_ra2_i = 0; chk_wa_i = 0;
   endtask

   task automatic do_reset();
      idle();
      rst_ni = 0;
      repeat (2) @(posedge clk_i);
      #1 rst_ni = 1;
      model_reset();
   endtask

   // ---------------- directed tests ----------------
   task automatic test_reset();
      idle();
      rst_ni = 0;
      #12;
      n_tests++;
      if ({rf_wen_o, rf_wa_o, rf_wd_o, rf_wd2_o, rf_rd64_o} !== '0) begin
         n_fail++;
         $display("FAIL reset_rf: got wen=%0b wa=%0d wd=%0h wd2=%0h rd64=%0b want all 0",
                  rf_wen_o, rf_wa_o, rf_wd_o, rf_wd2_o, rf_rd64_o);
      end
      n_tests++;
      if (fifo_count_o !== 0 || ll_ready_o !== 1 || hazard_o !== 0) begin
         n_fail++;
         $display("FAIL reset_status: got cnt=%0d rdy=%0b haz=%0b want 0/1/0",
                  fifo_count_o, ll_ready_o, hazard_o);
      end
      @(posedge clk_i);
      #1 rst_ni = 1;
      model_reset();
   endtask

   task automatic test_pipe_write();
      idle();
      pipe_wen_i = 1; pipe_wa_i = 5; pipe_wd_i = 32'h1234;
      tick();
      idle();
      n_tests++;
      if (rf_wen_o !== 1 || rf_wa_o !== 5 || rf_wd_o !== 32'h1234 ||
          rf_rd64_o !== 0) begin
         n_fail++;
         $display("FAIL pipe_write: got wen=%0b wa=%0d wd=%0h rd64=%0b want 1/5/1234/0",
                  rf_wen_o, rf_wa_o, rf_wd_o, rf_rd64_o);
      end
      tick();
      n_tests++;
      if (rf_wen_o !== 0) begin
         n_fail++;
         $display("FAIL pipe_idle: got wen=%0b want 0", rf_wen_o);
      end
   endtask

   task automatic test_pair_write();
      idle();
      pipe_wen_i = 1; pipe_wa_i = 6; pipe_rd64_i = 1;
      pipe_wd_i = 32'hAAAA_0001; pipe_wd2_i = 32'hBBBB_0002;
      tick();
      idle();
      n_tests++;
      if (rf_wen_o !== 1 || rf_wa_o !== 6 || rf_rd64_o !== 1 ||
          rf_wd_o !== 32'hAAAA_0001 || rf_wd2_o !== 32'hBBBB_0002) begin
         n_fail++;
         $display("FAIL pair_write: got wen=%0b wa=%0d rd64=%0b wd=%0h wd2=%0h",
                  rf_wen_o, rf_wa_o, rf_rd64_o, rf_wd_o, rf_wd2_o);
      end
      tick();
   endtask

   task automatic test_scoreboard();
      idle();
      ll_issue_i = 1; ll_issue_rd_i = 7;
      tick();
      idle();
      chk_ra1_i = 7;
      #1;
      n_tests++;
      if (hazard_o !== 1) begin
         n_fail++;
         $display("FAIL sb_set: got hazard=%0b want 1", hazard_o);
      end
      ll_valid_i = 1; ll_wa_i = 7; ll_wd_i = 32'hCAFE;
      tick();
      ll_valid_i = 0;
      n_tests++;
      if (fifo_count_o !== 1 || hazard_o !== 1) begin
         n_fail++;
         $display("FAIL sb_push: got cnt=%0d haz=%0b want 1/1",
                  fifo_count_o, hazard_o);
      end
      tick();
      n_tests++;
      if (rf_wen_o !== 1 || rf_wa_o !== 7 || rf_wd_o !== 32'hCAFE ||
          rf_rd64_o !== 0 || rf_wd2_o !== 0) begin
         n_fail++;
         $display("FAIL sb_drain: got wen=%0b wa=%0d wd=%0h want 1/7/cafe",
                  rf_wen_o, rf_wa_o, rf_wd_o);
      end
      n_tests++;
      if (hazard_o !== 0 || fifo_count_o !== 0) begin
         n_fail++;
         $display("FAIL sb_clear: got haz=%0b cnt=%0d want 0/0",
                  hazard_o, fifo_count_o);
      end
      idle();
      tick();
   endtask

   task automatic test_full_fifo();
      idle();
      pipe_wen_i = 1; pipe_wa_i = 1; pipe_wd_i = 32'h11;
      ll_valid_i = 1; ll_wa_i = 10; ll_wd_i = 32'hA1;
      tick();
      ll_wa_i = 11; ll_wd_i = 32'hA2;
      tick();
      n_tests++;
      if (fifo_count_o !== 2 || ll_ready_o !== 0) begin
         n_fail++;
         $display("FAIL full_count: got cnt=%0d rdy=%0b want 2/0",
                  fifo_count_o, ll_ready_o);
      end
      ll_wa_i = 12; ll_wd_i = 32'hA3;
      tick();
      n_tests++;
      if (fifo_count_o !== 2) begin
         n_fail++;
         $display("FAIL full_reject: got cnt=%0d want 2", fifo_count_o);
      end
      idle();
      tick();
      n_tests++;
      if (rf_wen_o !== 1 || rf_wa_o !== 10 || rf_wd_o !== 32'hA1) begin
         n_fail++;
         $display("FAIL full_drain1: got wen=%0b wa=%0d wd=%0h want 1/10/a1",
                  rf_wen_o, rf_wa_o, rf_wd_o);
      end
      tick();
      n_tests++;
      if (rf_wen_o !== 1 || rf_wa_o !== 11 || rf_wd_o !== 32'hA2 ||
          fifo_count_o !== 0) begin
         n_fail++;
         $display("FAIL full_drain2: got wen=%0b wa=%0d wd=%0h cnt=%0d want 1/11/a2/0",
                  rf_wen_o, rf_wa_o, rf_wd_o, fifo_count_o);
      end
      tick();
   endtask

   task automatic test_debug_block();
      do_reset();
      ll_valid_i = 1; ll_wa_i = 3; ll_wd_i = 32'hD0D0;
      tick();
      ll_valid_i = 0;
      dm_wen_i = 1;
      for (int i = 0; i < 3; i++) begin
         tick();
         n_tests++;
         if (rf_wen_o !== 0 || fifo_count_o !== 1) begin
            n_fail++;
            $display("FAIL dm_block[%0d]: got wen=%0b cnt=%0d want 0/1",
                     i, rf_wen_o, fifo_count_o);
         end
      end
`ifdef AIRI5C_WB_PERF_CNT_EN
      n_tests++;
      if (drain_stall_cnt_o !== 16'd3) begin
         n_fail++;
         $display("FAIL dm_stall_cnt: got %0d want 3", drain_stall_cnt_o);
      end
`endif
      dm_wen_i = 0;
      tick();
      n_tests++;
      if (rf_wen_o !== 1 || rf_wa_o !== 3 || rf_wd_o !== 32'hD0D0) begin
         n_fail++;
         $display("FAIL dm_release: got wen=%0b wa=%0d wd=%0h want 1/3/d0d0",
                  rf_wen_o, rf_wa_o, rf_wd_o);
      end
   endtask

   task automatic test_set_wins();
      idle();
      ll_valid_i = 1; ll_wa_i = 9; ll_wd_i = 32'h99;
      pipe_wen_i = 1; pipe_wa_i = 2;
      tick();
      idle();
      ll_issue_i = 1; ll_issue_rd_i = 9;
      tick();
      idle();
      chk_ra2_i = 9;
      #1;
      n_tests++;
      if (rf_wa_o !== 9 || hazard_o !== 1) begin
         n_fail++;
         $display("FAIL set_wins: got wa=%0d haz=%0b want 9/1",
                  rf_wa_o, hazard_o);
      end
      idle();
      ll_issue_i = 1; ll_issue_rd_i = 0;
      tick();
      n_tests++;
      if (hazard_o !== 0) begin
         n_fail++;
         $display("FAIL x0_issue: got hazard=%0b want 0", hazard_o);
      end
      idle();
      tick();
      n_tests++;
      if (hazard_o !== 0) begin
         n_fail++;
         $display("FAIL x0_busy: got hazard=%0b want 0", hazard_o);
      end
   endtask

   task automatic test_reset_mid();
      idle();
      pipe_wen_i = 1;
      ll_issue_i = 1; ll_issue_rd_i = 12;
      ll_valid_i = 1; ll_wa_i = 13; ll_wd_i = 32'h55;
      tick();
      idle();
      chk_ra1_i = 12;
      #2 rst_ni = 0;
      #1;
      n_tests++;
      if (fifo_count_o !== 0 || hazard_o !== 0 || rf_wen_o !== 0 ||
          ll_ready_o !== 1) begin
         n_fail++;
         $display("FAIL reset_mid: got cnt=%0d haz=%0b wen=%0b rdy=%0b want 0/0/0/1",
                  fifo_count_o, hazard_o, rf_wen_o, ll_ready_o);
      end
      @(posedge clk_i);
      #1 rst_ni = 1;
      model_reset();
   endtask

   task automatic test_random();
      int errs;
      errs = 0;
      for (int c = 0; c < 3000; c++) begin
         dm_wen_i      = ($urandom_range(0, 9) == 0);
         pipe_wen_i    = ($urandom_range(0, 9) < 4);
         pipe_wa_i     = RA'($urandom_range(0, 31));
         pipe_wd_i     = $urandom;
         pipe_wd2_i    = $urandom;
         pipe_rd64_i   = $urandom_range(0, 1) == 1;
         ll_issue_i    = ($urandom_range(0, 9) < 3);
         ll_issue_rd_i = RA'($urandom_range(0, 7));
         ll_valid_i    = $urandom_range(0, 1) == 1;
         ll_wa_i       = RA'($urandom_range(0, 7));
         ll_wd_i       = $urandom;
         chk_ra1_i     = RA'($urandom_range(0, 7));
         chk_ra2_i     = RA'($urandom_range(0, 7));
         chk_wa_i      = RA'($urandom_range(0, 7));
         tick();
         n_tests++;
         if (rf_wen_o !== e_wen ||
             (e_wen && (rf_wa_o !== e_wa || rf_wd_o !== e_wd ||
                        rf_wd2_o !== e_wd2 || rf_rd64_o !== e_rd64))) begin
            n_fail++;
            if (errs++ < 10)
               $display("FAIL rand_rf[%0d]: got %0b/%0d/%0h/%0h/%0b want %0b/%0d/%0h/%0h/%0b",
                        c, rf_wen_o, rf_wa_o, rf_wd_o, rf_wd2_o, rf_rd64_o,
                        e_wen, e_wa, e_wd, e_wd2, e_rd64);
         end
         n_tests++;
         if (fifo_count_o !== m_q.size() ||
             ll_ready_o !== (m_q.size() != DEPTH) ||
             hazard_o !== m_hazard()) begin
            n_fail++;
            if (errs++ < 10)
               $display("FAIL rand_status[%0d]: got cnt=%0d rdy=%0b haz=%0b want %0d/%0b/%0b",
                        c, fifo_count_o, ll_ready_o, hazard_o, m_q.size(),
                        m_q.size() != DEPTH, m_hazard());
         end
`ifdef AIRI5C_WB_PERF_CNT_EN
         n_tests++;
         if (drain_stall_cnt_o !== 16'(m_stall)) begin
            n_fail++;
            if (errs++ < 10)
               $display("FAIL rand_stall[%0d]: got %0d want %0d",
                        c, drain_stall_cnt_o, m_stall);
         end
`endif
      end
      idle();
   endtask

   initial begin
      model_reset();
      test_reset();
      test_pipe_write();
      test_pair_write();
      test_scoreboard();
      test_full_fifo();
      test_debug_block();
      test_set_wins();
      test_reset_mid();
      test_random();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
